// File: rtl/pkg_amba3.sv
// Shared AMBA3 AXI types: channel attribute enums, the AR slice payload and the
// arbiter FSM state.
package pkg_amba3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type_e;

  typedef enum logic [1:0] {
    LOCK_NORMAL    = 2'b00,
    LOCK_EXCLUSIVE = 2'b01,
    LOCK_LOCKED    = 2'b10,
    LOCK_RSVD      = 2'b11
  } lock_type_e;

  typedef enum logic [3:0] {
    CACHE_NONE      = 4'h0,
    CACHE_BUF       = 4'h1,
    CACHE_CACHEABLE = 4'h2,
    CACHE_CBUF      = 4'h3,
    CACHE_RA        = 4'h6,
    CACHE_RA_BUF    = 4'h7,
    CACHE_WA        = 4'hA,
    CACHE_WA_BUF    = 4'hB,
    CACHE_RWA       = 4'hE,
    CACHE_RWA_BUF   = 4'hF
  } cache_attr_e;

  typedef enum logic [2:0] {
    PROT_NORMAL       = 3'b000,
    PROT_PRIV         = 3'b001,
    PROT_NONSEC       = 3'b010,
    PROT_PRIV_NONSEC  = 3'b011,
    PROT_INSTR        = 3'b100,
    PROT_PRIV_INSTR   = 3'b101,
    PROT_NONSEC_INSTR = 3'b110,
    PROT_ALL          = 3'b111
  } prot_attr_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_type_e;

  // Width-independent part of an AR request; id and addr widths are
  // per-instance, so the arbiter keeps them in registers beside this struct.
  typedef struct packed {
    logic [3:0]  len;
    logic [2:0]  size;
    burst_type_e burst;
    lock_type_e  lock;
    cache_attr_e cache;
    prot_attr_e  prot;
  } amba3_ar_t;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_HOLD = 1'b1
  } ar_state_e;

endpackage

// File: rtl/amba3_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr,
// wrapping cyclically. Shared by the read and write channel arbiters.
module amba3_rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!grant_valid && req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/amba3_axi_rd_arbiter.sv
// Shares one AXI3 read slave port between NUM_MST masters: round-robin AR through
// a one-entry slice, R beats steered back by the master index held in the top ID bits.
module amba3_axi_rd_arbiter
  import pkg_amba3::*;
#(
  parameter  int NUM_MST   = 2,
  parameter  int AXID_SIZE = 4,
  parameter  int ADDR_SIZE = 32,
  parameter  int DATA_SIZE = 128,
  parameter  int MAX_OUTS  = 4,
  localparam int IDX_W     = $clog2(NUM_MST),
  localparam int SID_W     = AXID_SIZE + IDX_W
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_MST*AXID_SIZE-1:0]   m_arid,
  input  logic [NUM_MST*ADDR_SIZE-1:0]   m_araddr,
  input  logic [NUM_MST*4-1:0]           m_arlen,
  input  logic [NUM_MST*3-1:0]           m_arsize,
  input  burst_type_e                    m_arburst [NUM_MST],
  input  lock_type_e                     m_arlock  [NUM_MST],
  input  cache_attr_e                    m_arcache [NUM_MST],
  input  prot_attr_e                     m_arprot  [NUM_MST],
  input  logic [NUM_MST-1:0]             m_arvalid,
  output logic [NUM_MST-1:0]             m_arready,
  output logic [AXID_SIZE-1:0]           m_rid,
  output logic [DATA_SIZE-1:0]           m_rdata,
  output resp_type_e                     m_rresp,
  output logic                           m_rlast,
  output logic [NUM_MST-1:0]             m_rvalid,
  input  logic [NUM_MST-1:0]             m_rready,
  output logic [SID_W-1:0]               s_arid,
  output logic [ADDR_SIZE-1:0]           s_araddr,
  output logic [3:0]                     s_arlen,
  output logic [2:0]                     s_arsize,
  output burst_type_e                    s_arburst,
  output lock_type_e                     s_arlock,
  output cache_attr_e                    s_arcache,
  output prot_attr_e                     s_arprot,
  output logic                           s_arvalid,
  input  logic                           s_arready,
  input  logic [SID_W-1:0]               s_rid,
  input  logic [DATA_SIZE-1:0]           s_rdata,
  input  resp_type_e                     s_rresp,
  input  logic                           s_rlast,
  input  logic                           s_rvalid,
  output logic                           s_rready,
  output logic                           err_rid
);

  localparam logic [3:0] CNT_MAX = 4'(MAX_OUTS);

  ar_state_e        state_reg;
  amba3_ar_t        attr_reg, attr_next;
  logic [SID_W-1:0] id_reg, id_next;
  logic [ADDR_SIZE-1:0] addr_reg, addr_next;
  logic             s_arvalid_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic             err_rid_reg;
  logic [3:0]       cnt_reg [NUM_MST];

  logic [NUM_MST-1:0] eligible, grant, inc, dec;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               grant_ok;
  logic [IDX_W-1:0]   r_idx;
  logic               r_idx_ok;
  logic               r_done;

  amba3_rr_arbiter #(.N(NUM_MST)) u_rr (
    .req         (eligible),
    .ptr         (ptr_reg),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign grant_ok  = (state_reg == AR_IDLE) && grant_valid && !areset;
  assign m_arready = grant_ok ? grant : '0;

  assign r_idx    = s_rid[SID_W-1 -: IDX_W];
  assign r_idx_ok = (int'(r_idx) < NUM_MST);
  assign r_done   = s_rvalid && s_rready && s_rlast && r_idx_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MST; gi++) begin : g_mst
      assign eligible[gi] = m_arvalid[gi] && (cnt_reg[gi] < CNT_MAX);
      assign inc[gi]      = grant_ok && grant[gi];
      assign dec[gi]      = r_done && (r_idx == IDX_W'(gi));
      assign m_rvalid[gi] = s_rvalid && r_idx_ok && (r_idx == IDX_W'(gi));
    end
  endgenerate

  // Beats tagged with a prefix that names no master are sunk so the slave never stalls.
  always_comb begin
    s_rready = !r_idx_ok;
    for (int i = 0; i < NUM_MST; i++) begin
      if (r_idx == IDX_W'(i)) s_rready = m_rready[i];
    end
  end

  assign m_rid   = s_rid[AXID_SIZE-1:0];
  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;

  always_comb begin
    attr_next = '0;
    addr_next = '0;
    id_next   = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (grant[i]) begin
        attr_next.len   = m_arlen[i*4 +: 4];
        attr_next.size  = m_arsize[i*3 +: 3];
        attr_next.burst = m_arburst[i];
        attr_next.lock  = m_arlock[i];
        attr_next.cache = m_arcache[i];
        attr_next.prot  = m_arprot[i];
        addr_next       = m_araddr[i*ADDR_SIZE +: ADDR_SIZE];
        id_next         = {grant_idx, m_arid[i*AXID_SIZE +: AXID_SIZE]};
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg     <= AR_IDLE;
      s_arvalid_reg <= 1'b0;
      attr_reg      <= '0;
      addr_reg      <= '0;
      id_reg        <= '0;
      ptr_reg       <= IDX_W'(NUM_MST - 1);
    end else begin
      case (state_reg)
        AR_IDLE: begin
          if (grant_valid) begin
            attr_reg      <= attr_next;
            addr_reg      <= addr_next;
            id_reg        <= id_next;
            s_arvalid_reg <= 1'b1;
            ptr_reg       <= grant_idx;
            state_reg     <= AR_HOLD;
          end
        end
        AR_HOLD: begin
          if (s_arready) begin
            s_arvalid_reg <= 1'b0;
            state_reg     <= AR_IDLE;
          end
        end
        default: state_reg <= AR_IDLE;
      endcase
    end
  end

  // Grant and final beat in the same cycle cancel; a final beat at zero is dropped.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NUM_MST; i++) begin
      if (areset) begin
        cnt_reg[i] <= '0;
      end else begin
        assert (!(dec[i] && !inc[i] && cnt_reg[i] == '0));
        if (inc[i] && !dec[i]) begin
          cnt_reg[i] <= cnt_reg[i] + 4'd1;
        end else if (dec[i] && !inc[i] && cnt_reg[i] != '0) begin
          cnt_reg[i] <= cnt_reg[i] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      err_rid_reg <= 1'b0;
    end else if (s_rvalid && !r_idx_ok) begin
      err_rid_reg <= 1'b1;
    end
  end

  assign s_arvalid = s_arvalid_reg;
  assign s_arid    = id_reg;
  assign s_araddr  = addr_reg;
  assign s_arlen   = attr_reg.len;
  assign s_arsize  = attr_reg.size;
  assign s_arburst = attr_reg.burst;
  assign s_arlock  = attr_reg.lock;
  assign s_arcache = attr_reg.cache;
  assign s_arprot  = attr_reg.prot;
  assign err_rid   = err_rid_reg;

endmodule

// File: tb/tb_amba3_axi_rd_arbiter.sv
// Scenario bench for the AXI read arbiter: three masters, two outstanding reads each,
// expected AR/R traffic queued as stimulus is driven and checked as it emerges.
module tb_amba3_axi_rd_arbiter;
  import pkg_amba3::*;

  localparam int NM = 3;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam int XW = 2;
  localparam int SW = IW + XW;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [NM*IW-1:0] m_arid;
  logic [NM*AW-1:0] m_araddr;
  logic [NM*4-1:0]  m_arlen;
  logic [NM*3-1:0]  m_arsize;
  burst_type_e      m_arburst [NM];
  lock_type_e       m_arlock  [NM];
  cache_attr_e      m_arcache [NM];
  prot_attr_e       m_arprot  [NM];
  logic [NM-1:0]    m_arvalid, m_arready;
  logic [IW-1:0]    m_rid;
  logic [DW-1:0]    m_rdata;
  resp_type_e       m_rresp;
  logic             m_rlast;
  logic [NM-1:0]    m_rvalid, m_rready;
  logic [SW-1:0]    s_arid;
  logic [AW-1:0]    s_araddr;
  logic [3:0]       s_arlen;
  logic [2:0]       s_arsize;
  burst_type_e      s_arburst;
  lock_type_e       s_arlock;
  cache_attr_e      s_arcache;
  prot_attr_e       s_arprot;
  logic             s_arvalid, s_arready;
  logic [SW-1:0]    s_rid;
  logic [DW-1:0]    s_rdata;
  resp_type_e       s_rresp;
  logic             s_rlast, s_rvalid, s_rready;
  logic             err_rid;

  amba3_axi_rd_arbiter #(
    .NUM_MST(NM), .AXID_SIZE(IW), .ADDR_SIZE(AW), .DATA_SIZE(DW), .MAX_OUTS(MO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .err_rid(err_rid)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [SW-1:0] id;
    logic [AW-1:0] addr;
    logic [3:0]    len;
  } ar_exp_t;

  typedef struct {
    logic [NM-1:0] vld;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];

  // Drive phase: just after the rising edge.
  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  // Sample phase: falling edge, after this cycle's drives have settled.
  task automatic smp();
    @(negedge aclk);
  endtask

  task automatic set_ar(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                        input logic [3:0] len);
    m_arid[m*IW +: IW]   = id;
    m_araddr[m*AW +: AW] = addr;
    m_arlen[m*4 +: 4]    = len;
    m_arsize[m*3 +: 3]   = 3'd4;
    m_arburst[m]         = BURST_INCR;
    m_arlock[m]          = LOCK_NORMAL;
    m_arcache[m]         = CACHE_BUF;
    m_arprot[m]          = PROT_PRIV;
  endtask

  task automatic do_reset();
    areset    = 1'b1;
    m_arvalid = '0;
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    s_arready = 1'b1;
    m_rready  = '1;
    cyc();
    cyc();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    ar_exp_t e;
    areset    = 1'b1;
    m_arvalid = 3'b111;
    cyc();
    cyc();
    smp();
    checks++;
    if (m_arready !== 3'b000) begin
      failures++; $display("FAIL reset_arready got=%b exp=000", m_arready);
    end
    checks++;
    if (s_arvalid !== 1'b0) begin
      failures++; $display("FAIL reset_s_arvalid got=%b exp=0", s_arvalid);
    end
    checks++;
    if (s_arid !== '0 || s_araddr !== '0 || s_arlen !== '0) begin
      failures++; $display("FAIL reset_s_ar_fields got id=%h addr=%h len=%h exp=0", s_arid, s_araddr, s_arlen);
    end
    checks++;
    if (s_arburst !== BURST_FIXED || s_arlock !== LOCK_NORMAL) begin
      failures++; $display("FAIL reset_s_ar_attr got burst=%0d lock=%0d exp=0/0", s_arburst, s_arlock);
    end
    checks++;
    if (err_rid !== 1'b0) begin
      failures++; $display("FAIL reset_err_rid got=%b exp=0", err_rid);
    end
    for (int i = 0; i < NM; i++) begin
      checks++;
      if (dut.cnt_reg[i] !== 4'd0) begin
        failures++; $display("FAIL reset_cnt%0d got=%0d exp=0", i, dut.cnt_reg[i]);
      end
    end
    cyc();
    m_arvalid = '0;
    areset    = 1'b0;
    e = '{id: '0, addr: '0, len: '0};
    $display("test_reset done id=%h", e.id);
  endtask

  task automatic test_single();
    ar_exp_t e;
    r_exp_t  r;
    logic [DW-1:0] d;
    set_ar(0, 4'h5, 32'h100, 4'd3);
    m_arvalid = 3'b001;
    ar_q.push_back('{id: {2'd0, 4'h5}, addr: 32'h100, len: 4'd3});
    smp();
    checks++;
    if (m_arready !== 3'b001) begin
      failures++; $display("FAIL single_arready got=%b exp=001", m_arready);
    end
    checks++;
    if (s_arvalid !== 1'b0) begin
      failures++; $display("FAIL single_early_valid got=%b exp=0", s_arvalid);
    end
    cyc();
    m_arvalid = '0;
    smp();
    checks++;
    if (s_arvalid !== 1'b1) begin
      failures++; $display("FAIL single_s_arvalid got=%b exp=1", s_arvalid);
    end
    if (s_arvalid && s_arready && ar_q.size() > 0) begin
      e = ar_q.pop_front();
      checks++;
      if (s_arid !== e.id || s_araddr !== e.addr || s_arlen !== e.len || s_arburst !== BURST_INCR) begin
        failures++; $display("FAIL single_ar got id=%h addr=%h len=%0d burst=%0d exp id=%h addr=%h len=%0d burst=1",
                             s_arid, s_araddr, s_arlen, s_arburst, e.id, e.addr, e.len);
      end
      $display("AR id=%h addr=%h len=%0d", s_arid, s_araddr, s_arlen);
    end
    checks++;
    if (dut.cnt_reg[0] !== 4'd1) begin
      failures++; $display("FAIL single_cnt_inc got=%0d exp=1", dut.cnt_reg[0]);
    end
    cyc();
    for (int b = 0; b < 4; b++) begin
      d        = 32'hD000_0000 + 32'(b);
      s_rid    = {2'd0, 4'h5};
      s_rdata  = d;
      s_rresp  = RESP_OKAY;
      s_rlast  = (b == 3);
      s_rvalid = 1'b1;
      r_q.push_back('{vld: 3'b001, id: 4'h5, data: d, last: (b == 3)});
      smp();
      checks++;
      if (s_rready !== 1'b1) begin
        failures++; $display("FAIL single_rready beat=%0d got=%b exp=1", b, s_rready);
      end
      if (s_rvalid && s_rready && r_q.size() > 0) begin
        r = r_q.pop_front();
        checks++;
        if (m_rvalid !== r.vld || m_rid !== r.id || m_rdata !== r.data || m_rlast !== r.last) begin
          failures++; $display("FAIL single_r beat=%0d got vld=%b id=%h data=%h last=%b exp vld=%b id=%h data=%h last=%b",
                               b, m_rvalid, m_rid, m_rdata, m_rlast, r.vld, r.id, r.data, r.last);
        end
        $display("R beat=%0d vld=%b id=%h data=%h last=%b", b, m_rvalid, m_rid, m_rdata, m_rlast);
      end
      cyc();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    smp();
    checks++;
    if (dut.cnt_reg[0] !== 4'd0 || r_q.size() != 0 || ar_q.size() != 0) begin
      failures++; $display("FAIL single_drain got cnt0=%0d rq=%0d arq=%0d exp=0/0/0", dut.cnt_reg[0], r_q.size(), ar_q.size());
    end
    cyc();
  endtask

  task automatic test_alternate();
    ar_exp_t e;
    logic [NM-1:0] exp_rdy;
    do_reset();
    set_ar(0, 4'h1, 32'h1000, 4'd0);
    set_ar(1, 4'h2, 32'h2000, 4'd1);
    m_arvalid = 3'b011;
    for (int k = 0; k < 2; k++) begin
      ar_q.push_back('{id: {2'd0, 4'h1}, addr: 32'h1000, len: 4'd0});
      ar_q.push_back('{id: {2'd1, 4'h2}, addr: 32'h2000, len: 4'd1});
    end
    for (int c = 0; c < 8; c++) begin
      smp();
      if (c % 2 == 0) begin
        exp_rdy = '0;
        if (ar_q.size() > 0) exp_rdy = 3'b001 << ar_q[0].id[SW-1 -: XW];
        checks++;
        if (m_arready !== exp_rdy || s_arvalid !== 1'b0) begin
          failures++; $display("FAIL alt_grant c=%0d got rdy=%b vld=%b exp rdy=%b vld=0", c, m_arready, s_arvalid, exp_rdy);
        end
      end else begin
        checks++;
        if (s_arvalid !== 1'b1 || m_arready !== 3'b000) begin
          failures++; $display("FAIL alt_hold c=%0d got vld=%b rdy=%b exp vld=1 rdy=000", c, s_arvalid, m_arready);
        end
        if (s_arvalid && s_arready && ar_q.size() > 0) begin
          e = ar_q.pop_front();
          checks++;
          if (s_arid !== e.id || s_araddr !== e.addr || s_arlen !== e.len) begin
            failures++; $display("FAIL alt_ar c=%0d got id=%h addr=%h len=%0d exp id=%h addr=%h len=%0d",
                                 c, s_arid, s_araddr, s_arlen, e.id, e.addr, e.len);
          end
          $display("AR c=%0d id=%h addr=%h", c, s_arid, s_araddr);
        end
      end
      cyc();
    end
    m_arvalid = '0;
    checks++;
    if (ar_q.size() != 0) begin
      failures++; $display("FAIL alt_leftover got=%0d exp=0", ar_q.size());
    end
  endtask

  task automatic test_max_outs();
    ar_exp_t e;
    logic [NM-1:0] exp_rdy;
    logic          exp_vld;
    do_reset();
    set_ar(0, 4'h3, 32'h3000, 4'd0);
    m_arvalid = 3'b001;
    for (int k = 0; k < 3; k++) ar_q.push_back('{id: {2'd0, 4'h3}, addr: 32'h3000, len: 4'd0});
    for (int c = 0; c < 8; c++) begin
      exp_rdy = (c < 4 && c % 2 == 0) ? 3'b001 : 3'b000;
      exp_vld = (c < 4 && c % 2 == 1);
      smp();
      checks++;
      if (m_arready !== exp_rdy || s_arvalid !== exp_vld) begin
        failures++; $display("FAIL maxouts_c%0d got rdy=%b vld=%b exp rdy=%b vld=%b", c, m_arready, s_arvalid, exp_rdy, exp_vld);
      end
      if (s_arvalid && s_arready && ar_q.size() > 0) begin
        e = ar_q.pop_front();
        $display("AR c=%0d id=%h", c, s_arid);
      end
      cyc();
    end
    s_rid    = {2'd0, 4'h3};
    s_rdata  = 32'hCAFE_0001;
    s_rlast  = 1'b1;
    s_rvalid = 1'b1;
    smp();
    checks++;
    if (m_arready !== 3'b000 || m_rvalid !== 3'b001 || dut.cnt_reg[0] !== 4'd2) begin
      failures++; $display("FAIL maxouts_rlast got rdy=%b rvld=%b cnt=%0d exp rdy=000 rvld=001 cnt=2", m_arready, m_rvalid, dut.cnt_reg[0]);
    end
    cyc();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    smp();
    checks++;
    if (m_arready !== 3'b001) begin
      failures++; $display("FAIL maxouts_regain got=%b exp=001", m_arready);
    end
    cyc();
    m_arvalid = '0;
    smp();
    checks++;
    if (s_arvalid !== 1'b1) begin
      failures++; $display("FAIL maxouts_third got vld=%b exp=1", s_arvalid);
    end
    if (s_arvalid && s_arready && ar_q.size() > 0) begin
      e = ar_q.pop_front();
      checks++;
      if (s_arid !== e.id || s_araddr !== e.addr) begin
        failures++; $display("FAIL maxouts_third_ar got id=%h addr=%h exp id=%h addr=%h", s_arid, s_araddr, e.id, e.addr);
      end
      $display("AR third id=%h", s_arid);
    end
    cyc();
    checks++;
    if (ar_q.size() != 0) begin
      failures++; $display("FAIL maxouts_leftover got=%0d exp=0", ar_q.size());
    end
  endtask

  task automatic test_stall();
    ar_exp_t e;
    do_reset();
    s_arready = 1'b0;
    set_ar(1, 4'h7, 32'h2000, 4'd1);
    m_arvalid = 3'b010;
    ar_q.push_back('{id: {2'd1, 4'h7}, addr: 32'h2000, len: 4'd1});
    smp();
    checks++;
    if (m_arready !== 3'b010) begin
      failures++; $display("FAIL stall_grant got=%b exp=010", m_arready);
    end
    cyc();
    set_ar(0, 4'hB, 32'h5000, 4'd2);
    m_arvalid = 3'b011;
    for (int c = 0; c < 5; c++) begin
      smp();
      checks++;
      if (s_arvalid !== 1'b1 || s_arid !== {2'd1, 4'h7} || s_araddr !== 32'h2000 || s_arlen !== 4'd1 || m_arready !== 3'b000) begin
        failures++; $display("FAIL stall_hold c=%0d got vld=%b id=%h addr=%h len=%0d rdy=%b exp vld=1 id=17 addr=00002000 len=1 rdy=000",
                             c, s_arvalid, s_arid, s_araddr, s_arlen, m_arready);
      end
      cyc();
    end
    s_arready = 1'b1;
    m_arvalid = '0;
    smp();
    if (s_arvalid && s_arready && ar_q.size() > 0) begin
      e = ar_q.pop_front();
      checks++;
      if (s_arid !== e.id || s_araddr !== e.addr || s_arlen !== e.len) begin
        failures++; $display("FAIL stall_accept got id=%h addr=%h exp id=%h addr=%h", s_arid, s_araddr, e.id, e.addr);
      end
      $display("AR accepted id=%h addr=%h", s_arid, s_araddr);
    end
    cyc();
    smp();
    checks++;
    if (s_arvalid !== 1'b0 || m_arready !== 3'b000 || ar_q.size() != 0) begin
      failures++; $display("FAIL stall_after got vld=%b rdy=%b arq=%0d exp 0/000/0", s_arvalid, m_arready, ar_q.size());
    end
    cyc();
  endtask

  task automatic test_bad_rid();
    do_reset();
    m_rready = '0;
    s_rid    = {2'd3, 4'hA};
    s_rdata  = 32'hBAD0_0000;
    s_rlast  = 1'b1;
    s_rvalid = 1'b1;
    smp();
    checks++;
    if (m_rvalid !== 3'b000 || s_rready !== 1'b1 || err_rid !== 1'b0) begin
      failures++; $display("FAIL badrid_beat got rvld=%b rready=%b err=%b exp 000/1/0", m_rvalid, s_rready, err_rid);
    end
    cyc();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    smp();
    checks++;
    if (err_rid !== 1'b1) begin
      failures++; $display("FAIL badrid_err got=%b exp=1", err_rid);
    end
    cyc();
    cyc();
    smp();
    checks++;
    if (err_rid !== 1'b1 || dut.cnt_reg[0] !== 4'd0 || dut.cnt_reg[1] !== 4'd0 || dut.cnt_reg[2] !== 4'd0) begin
      failures++; $display("FAIL badrid_sticky got err=%b cnt=%0d/%0d/%0d exp 1 0/0/0",
                           err_rid, dut.cnt_reg[0], dut.cnt_reg[1], dut.cnt_reg[2]);
    end
    $display("R sunk prefix=3 err_rid=%b", err_rid);
    cyc();
    m_rready = '1;
  endtask

  task automatic test_reset_hold();
    do_reset();
    set_ar(1, 4'h9, 32'h4000, 4'd0);
    m_arvalid = 3'b010;
    for (int c = 0; c < 3; c++) begin
      smp();
      checks++;
      if (m_arready !== ((c % 2 == 0) ? 3'b010 : 3'b000)) begin
        failures++; $display("FAIL rsthold_c%0d got rdy=%b", c, m_arready);
      end
      cyc();
    end
    s_arready = 1'b0;
    m_arvalid = '0;
    smp();
    checks++;
    if (s_arvalid !== 1'b1 || dut.cnt_reg[1] !== 4'd2) begin
      failures++; $display("FAIL rsthold_pre got vld=%b cnt1=%0d exp 1/2", s_arvalid, dut.cnt_reg[1]);
    end
    cyc();
    areset = 1'b1;
    cyc();
    areset = 1'b0;
    set_ar(0, 4'hC, 32'h6000, 4'd0);
    m_arvalid = 3'b011;
    s_arready = 1'b1;
    smp();
    checks++;
    if (s_arvalid !== 1'b0 || dut.cnt_reg[0] !== 4'd0 || dut.cnt_reg[1] !== 4'd0) begin
      failures++; $display("FAIL rsthold_cleared got vld=%b cnt=%0d/%0d exp 0 0/0", s_arvalid, dut.cnt_reg[0], dut.cnt_reg[1]);
    end
    checks++;
    if (m_arready !== 3'b001) begin
      failures++; $display("FAIL rsthold_m0_first got=%b exp=001", m_arready);
    end
    cyc();
    m_arvalid = '0;
    smp();
    checks++;
    if (s_arvalid !== 1'b1 || s_arid !== {2'd0, 4'hC}) begin
      failures++; $display("FAIL rsthold_ar got vld=%b id=%h exp 1/0c", s_arvalid, s_arid);
    end
    $display("AR after reset id=%h", s_arid);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    areset    = 1'b1;
    m_arid    = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arsize  = '0;
    for (int i = 0; i < NM; i++) begin
      m_arburst[i] = BURST_FIXED;
      m_arlock[i]  = LOCK_NORMAL;
      m_arcache[i] = CACHE_NONE;
      m_arprot[i]  = PROT_NORMAL;
    end
    m_arvalid = '0;
    m_rready  = '1;
    s_arready = 1'b1;
    s_rid     = '0;
    s_rdata   = '0;
    s_rresp   = RESP_OKAY;
    s_rlast   = 1'b0;
    s_rvalid  = 1'b0;
    cyc();

    test_reset();
    test_single();
    test_alternate();
    test_max_outs();
    test_stall();
    test_bad_rid();
    test_reset_hold();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
